// File: rtl/mips_mem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_mem_resp: program loader and memory responder for a MIPS-style CPU  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_mem_resp #(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [ADRBITS-1:0] adr,
  input  logic [WIDTH-1:0]   writedata,
  output logic [WIDTH-1:0]   memdata,
  input  logic               ld_start,
  input  logic [ADRBITS-1:0] ld_len,
  input  logic               ld_valid,
  input  logic [WIDTH-1:0]   ld_data,
  output logic               ld_ready,
  output logic               cpu_reset,
  output logic               wr_strobe,
  output logic [ADRBITS-1:0] wr_adr,
  output logic [WIDTH-1:0]   wr_data,
  output logic [1:0]         state
);

  localparam int DEPTH = 2 ** ADRBITS;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    RELEASE = 2'b10,
    RUN     = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [ADRBITS-1:0] cnt_q, cnt_d;
  logic [ADRBITS-1:0] len_q, len_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [ADRBITS-1:0] wr_adr_q, wr_adr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               mem_we;
  logic [ADRBITS-1:0] mem_wa;
  logic [WIDTH-1:0]   mem_wd;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wr_strobe_d = 1'b0;
    wr_adr_d    = wr_adr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    mem_wa      = adr;
    mem_wd      = writedata;

    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          len_d   = ld_len;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          mem_we = 1'b1;
          mem_wa = cnt_q;
          mem_wd = ld_data;
          // The final handshake leaves cnt alone so a full-depth load never wraps.
          if (cnt_q == len_q) state_d = RELEASE;
          else                cnt_d   = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d = RUN;
      end
      RUN: begin
        if (memwrite) begin
          mem_we      = 1'b1;
          wr_strobe_d = 1'b1;
          wr_adr_d    = adr;
          wr_data_d   = writedata;
        end
        if (ld_start) begin
          state_d = LOAD;
          len_d   = ld_len;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_adr_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wr_strobe_q <= wr_strobe_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory has no reset; reset only blocks writes so contents survive.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_wa] <= mem_wd;
  end

  assign memdata   = (state_q == RUN && memread) ? mem_q[adr] : '0;
  assign ld_ready  = (state_q == LOAD);
  assign cpu_reset = (state_q != RUN);
  assign wr_strobe = wr_strobe_q;
  assign wr_adr    = wr_adr_q;
  assign wr_data   = wr_data_q;
  assign state     = state_q;

endmodule
`default_nettype wire
